// File: rtl/fire4_squeeze_conv_if.sv
// Handshake and ROM bundle for the fire4 squeeze 1x1 conv engine.
// The engine uses the master side; the stream/ROM environment uses slave.
interface fire4_squeeze_conv_if #(
  parameter int WIDTH = 16,
  parameter int ADDR  = 10,
  parameter int NUM   = 32
);
  logic                      act_valid;
  logic                      act_ready;
  logic [WIDTH-1:0]          act_data;
  logic [ADDR-1:0]           rom_address;
  logic [0:NUM-1][WIDTH-1:0] rom_out;
  logic                      out_valid;
  logic                      out_ready;
  logic [0:NUM-1][WIDTH-1:0] out_data;
  logic                      out_last;

  modport master (
    input  act_valid, act_data, rom_out, out_ready,
    output act_ready, rom_address, out_valid, out_data, out_last
  );

  modport slave (
    output act_valid, act_data, rom_out, out_ready,
    input  act_ready, rom_address, out_valid, out_data, out_last
  );
endinterface

// File: rtl/fire4_squeeze_conv.sv
// fire4 squeeze 1x1 conv: NUM parallel MACs over CIN channel beats,
// then ReLU + saturation into one held output pixel.
module fire4_squeeze_conv #(
  parameter int WIDTH  = 16,
  parameter int ADDR   = 10,
  parameter int NUM    = 32,
  parameter int CIN    = 128,
  parameter int FRAC   = 8,
  parameter int PIXELS = 3025,
  parameter int ACCW   = 2*WIDTH+8
) (
  input logic clk,
  input logic rst,
  fire4_squeeze_conv_if.master bus
);

  localparam int CHW = (CIN > 1) ? $clog2(CIN) : 1;
  localparam int PXW = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam int PW  = 2*WIDTH;
  localparam logic signed [ACCW-1:0] SAT_MAX =
    {{(ACCW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {ACC, FLUSH1, FLUSH2, OUT} state_t;

  state_t state_q, state_d;
  logic [CHW-1:0] ch_q;
  logic [PXW-1:0] pix_q;
  logic p_valid_q;
  logic signed [PW-1:0] prod_q [NUM];
  logic signed [PW-1:0] prod_d [NUM];
  logic signed [ACCW-1:0] acc_q [NUM];
  logic [0:NUM-1][WIDTH-1:0] out_q;
  logic [0:NUM-1][WIDTH-1:0] res;
  logic out_last_q;
  logic beat, ch_last, out_fire;

  function automatic logic signed [PW-1:0] sx(
    input logic [WIDTH-1:0] v
  );
    return {{WIDTH{v[WIDTH-1]}}, v};
  endfunction

  // Arithmetic shift truncates toward -inf before clamping.
  function automatic logic [WIDTH-1:0] relu_sat(
    input logic signed [ACCW-1:0] a
  );
    logic signed [ACCW-1:0] r;
    r = a >>> FRAC;
    if (r < 0) return '0;
    if (r > SAT_MAX) return {1'b0, {(WIDTH-1){1'b1}}};
    return r[WIDTH-1:0];
  endfunction

  assign bus.act_ready   = (state_q == ACC) && !rst;
  assign bus.rom_address = ADDR'(ch_q);
  assign bus.out_valid   = (state_q == OUT);
  assign bus.out_data    = out_q;
  assign bus.out_last    = out_last_q;

  assign beat     = bus.act_valid && bus.act_ready;
  assign ch_last  = (ch_q == CHW'(CIN-1));
  assign out_fire = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACC:     if (beat && ch_last) state_d = FLUSH1;
      FLUSH1:  state_d = FLUSH2;
      FLUSH2:  state_d = OUT;
      OUT:     if (out_fire) state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  always_comb begin
    res = '0;
    for (int k = 0; k < NUM; k++) begin
      prod_d[k] = sx(bus.act_data) * sx(bus.rom_out[k]);
      res[k]    = relu_sat(acc_q[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (beat) begin
      for (int k = 0; k < NUM; k++) prod_q[k] <= prod_d[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACC;
      ch_q       <= '0;
      pix_q      <= '0;
      p_valid_q  <= 1'b0;
      out_q      <= '0;
      out_last_q <= 1'b0;
      for (int k = 0; k < NUM; k++) acc_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      p_valid_q <= beat;
      if (beat) ch_q <= ch_last ? '0 : ch_q + 1'b1;
      if (state_q == FLUSH2) begin
        out_q      <= res;
        out_last_q <= (pix_q == PXW'(PIXELS-1));
      end
      if (out_fire)
        pix_q <= (pix_q == PXW'(PIXELS-1)) ? '0 : pix_q + 1'b1;
      // Clear on handshake can never collide with a pending product.
      for (int k = 0; k < NUM; k++) begin
        if (out_fire)
          acc_q[k] <= '0;
        else if (p_valid_q)
          acc_q[k] <= acc_q[k]
                    + {{(ACCW-PW){prod_q[k][PW-1]}}, prod_q[k]};
      end
    end
  end

endmodule

// File: tb/tb_fire4_squeeze_conv.sv
// Scoreboard bench for fire4_squeeze_conv with a 3-pixel frame
// so frame wrap and out_last are reachable.
module tb_fire4_squeeze_conv;
  localparam int WIDTH = 16;
  localparam int ADDR  = 10;
  localparam int NUM   = 32;
  localparam int CIN   = 128;
  localparam int FRAC  = 8;
  localparam int PIX   = 3;

  typedef logic [0:NUM-1][WIDTH-1:0] pix_t;
  typedef struct {
    pix_t data;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fire4_squeeze_conv_if #(
    .WIDTH(WIDTH), .ADDR(ADDR), .NUM(NUM)
  ) bus ();

  fire4_squeeze_conv #(
    .WIDTH(WIDTH), .ADDR(ADDR), .NUM(NUM), .CIN(CIN),
    .FRAC(FRAC), .PIXELS(PIX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  exp_t sb[$];
  logic [WIDTH-1:0] wmem [NUM][CIN];
  logic [WIDTH-1:0] acts [CIN];
  int n_vec = 0;
  int n_err = 0;
  int model_pix = 0;

  always_comb begin
    bus.rom_out = '0;
    for (int k = 0; k < NUM; k++)
      bus.rom_out[k] = wmem[k][int'(bus.rom_address) % CIN];
  end

  function automatic logic [WIDTH-1:0] rnd(input int m);
    int v;
    v = int'($urandom_range(2*m)) - m;
    return v[WIDTH-1:0];
  endfunction

  task automatic set_w(input logic [WIDTH-1:0] ev,
                       input logic [WIDTH-1:0] od);
    for (int k = 0; k < NUM; k++)
      for (int i = 0; i < CIN; i++)
        wmem[k][i] = (k % 2 == 0) ? ev : od;
  endtask

  task automatic set_a(input logic [WIDTH-1:0] a);
    for (int i = 0; i < CIN; i++) acts[i] = a;
  endtask

  task automatic set_rand(input int wm, input int am);
    for (int k = 0; k < NUM; k++)
      for (int i = 0; i < CIN; i++) wmem[k][i] = rnd(wm);
    for (int i = 0; i < CIN; i++) acts[i] = rnd(am);
  endtask

  task automatic push_expected();
    exp_t e;
    longint acc, r, mx;
    mx = (longint'(1) <<< (WIDTH-1)) - 1;
    for (int k = 0; k < NUM; k++) begin
      acc = 0;
      for (int i = 0; i < CIN; i++)
        acc += longint'($signed(wmem[k][i]))
             * longint'($signed(acts[i]));
      r = acc >>> FRAC;
      if (r < 0) e.data[k] = '0;
      else if (r > mx) e.data[k] = WIDTH'(mx);
      else e.data[k] = WIDTH'(r);
    end
    e.last = (model_pix == PIX-1);
    model_pix = (model_pix + 1) % PIX;
    sb.push_back(e);
  endtask

  task automatic send_beats(input int nb, input int bubble);
    int i = 0;
    int guard = 0;
    while (i < nb) begin
      @(negedge clk);
      bus.act_valid = ($urandom_range(99) >= bubble);
      bus.act_data  = bus.act_valid ? acts[i] : WIDTH'($urandom);
      if (bus.act_valid && bus.act_ready) i++;
      guard++;
      if (guard > 20*CIN) begin
        $display("FAIL send_beats timeout got %0d want %0d", i, nb);
        $fatal(1);
      end
    end
  endtask

  task automatic collect(output pix_t d, output logic l,
                         output int n);
    n = 0;
    do begin
      @(negedge clk);
      bus.act_valid = 1'b0;
      n++;
      if (n > 1000) begin
        $display("FAIL collect timeout got no out_valid want 1");
        $fatal(1);
      end
    end while (!bus.out_valid);
    d = bus.out_data;
    l = bus.out_last;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.act_valid = 1'b0;
    bus.act_data  = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_vec += 5;
    if (bus.act_ready !== 1'b0) begin
      n_err++; $display("FAIL rst_ready got %b want 0", bus.act_ready);
    end
    if (bus.rom_address !== '0) begin
      n_err++; $display("FAIL rst_addr got %h want 0", bus.rom_address);
    end
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_valid got %b want 0", bus.out_valid);
    end
    if (bus.out_data !== '0) begin
      n_err++; $display("FAIL rst_data got %h want 0", bus.out_data);
    end
    if (bus.out_last !== 1'b0) begin
      n_err++; $display("FAIL rst_last got %b want 0", bus.out_last);
    end
    rst = 1'b0;
    model_pix = 0;
    @(negedge clk);
    n_vec++;
    if (bus.act_ready !== 1'b1) begin
      n_err++; $display("FAIL post_rst_ready got %b want 1", bus.act_ready);
    end
  endtask

  task automatic test_half();
    pix_t d, want;
    logic l;
    int n;
    exp_t e;
    want = {NUM{16'h4000}};
    set_w(16'h0080, 16'h0080);
    set_a(16'h0100);
    push_expected();
    send_beats(CIN, 0);
    collect(d, l, n);
    e = sb.pop_front();
    n_vec += 4;
    if (n !== 3) begin
      n_err++; $display("FAIL half_latency got %0d want 3", n);
    end
    if (d !== want) begin
      n_err++; $display("FAIL half_const got %h want %h", d, want);
    end
    if (d !== e.data) begin
      n_err++; $display("FAIL half_data got %h want %h", d, e.data);
    end
    if (l !== e.last) begin
      n_err++; $display("FAIL half_last got %b want %b", l, e.last);
    end
  endtask

  task automatic test_saturate();
    pix_t d, want;
    logic l;
    int n;
    exp_t e;
    want = {NUM{16'h7fff}};
    set_w(16'h0100, 16'h0100);
    set_a(16'h0100);
    push_expected();
    send_beats(CIN, 0);
    collect(d, l, n);
    e = sb.pop_front();
    n_vec += 3;
    if (d !== want) begin
      n_err++; $display("FAIL sat_const got %h want %h", d, want);
    end
    if (d !== e.data) begin
      n_err++; $display("FAIL sat_data got %h want %h", d, e.data);
    end
    if (l !== e.last) begin
      n_err++; $display("FAIL sat_last got %b want %b", l, e.last);
    end
  endtask

  task automatic test_relu();
    pix_t d;
    logic l;
    int n;
    exp_t e;
    set_w(16'hff00, 16'h0100);
    for (int p = 0; p < 2; p++) begin
      set_a(p == 0 ? 16'h0100 : 16'h0001);
      push_expected();
      send_beats(CIN, 0);
      collect(d, l, n);
      e = sb.pop_front();
      n_vec += 4;
      if (d !== e.data) begin
        n_err++; $display("FAIL relu_data%0d got %h want %h", p, d, e.data);
      end
      if (l !== e.last) begin
        n_err++; $display("FAIL relu_last%0d got %b want %b", p, l, e.last);
      end
      if (d[0] !== 16'h0000) begin
        n_err++; $display("FAIL relu_even%0d got %h want 0000", p, d[0]);
      end
      if (d[1] !== (p == 0 ? 16'h7fff : 16'h0080)) begin
        n_err++; $display("FAIL relu_odd%0d got %h want %h", p, d[1],
                          (p == 0 ? 16'h7fff : 16'h0080));
      end
    end
  endtask

  task automatic test_random_bubbles();
    pix_t d;
    logic l;
    int n;
    exp_t e;
    for (int p = 0; p < 3; p++) begin
      set_rand(256, 512);
      push_expected();
      send_beats(CIN, 35);
      collect(d, l, n);
      e = sb.pop_front();
      n_vec += 2;
      if (d !== e.data) begin
        n_err++; $display("FAIL rand_data%0d got %h want %h", p, d, e.data);
      end
      if (l !== e.last) begin
        n_err++; $display("FAIL rand_last%0d got %b want %b", p, l, e.last);
      end
    end
  endtask

  task automatic test_backpressure();
    pix_t d;
    logic l;
    int n;
    exp_t e;
    set_rand(256, 512);
    push_expected();
    send_beats(CIN, 10);
    bus.out_ready = 1'b0;
    collect(d, l, n);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      bus.act_valid = 1'b1;
      bus.act_data  = WIDTH'($urandom);
      n_vec += 4;
      if (bus.out_data !== d) begin
        n_err++; $display("FAIL bp_hold%0d got %h want %h", c, bus.out_data, d);
      end
      if (bus.out_valid !== 1'b1) begin
        n_err++; $display("FAIL bp_valid%0d got %b want 1", c, bus.out_valid);
      end
      if (bus.act_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_ready%0d got %b want 0", c, bus.act_ready);
      end
      if (bus.rom_address !== '0) begin
        n_err++; $display("FAIL bp_addr%0d got %h want 0", c, bus.rom_address);
      end
    end
    bus.out_ready = 1'b1;
    bus.act_valid = 1'b0;
    e = sb.pop_front();
    n_vec += 2;
    if (d !== e.data) begin
      n_err++; $display("FAIL bp_data got %h want %h", d, e.data);
    end
    if (l !== e.last) begin
      n_err++; $display("FAIL bp_last got %b want %b", l, e.last);
    end
    set_w(16'h0080, 16'h0080);
    set_a(16'h0100);
    push_expected();
    send_beats(CIN, 20);
    collect(d, l, n);
    e = sb.pop_front();
    n_vec += 2;
    if (d !== e.data) begin
      n_err++; $display("FAIL bp_next got %h want %h", d, e.data);
    end
    if (l !== e.last) begin
      n_err++; $display("FAIL bp_next_last got %b want %b", l, e.last);
    end
  endtask

  task automatic test_reset_midstream();
    pix_t d, want;
    logic l;
    int n;
    exp_t e;
    want = {NUM{16'h4000}};
    set_rand(256, 512);
    send_beats(50, 20);
    @(negedge clk);
    rst = 1'b1;
    bus.act_valid = 1'b0;
    @(negedge clk);
    n_vec += 4;
    if (bus.out_data !== '0) begin
      n_err++; $display("FAIL mid_rst_data got %h want 0", bus.out_data);
    end
    if (bus.act_ready !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_ready got %b want 0", bus.act_ready);
    end
    if (bus.rom_address !== '0) begin
      n_err++; $display("FAIL mid_rst_addr got %h want 0", bus.rom_address);
    end
    if (bus.out_valid !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_valid got %b want 0", bus.out_valid);
    end
    rst = 1'b0;
    model_pix = 0;
    set_w(16'h0080, 16'h0080);
    set_a(16'h0100);
    push_expected();
    send_beats(CIN, 0);
    collect(d, l, n);
    e = sb.pop_front();
    n_vec += 3;
    if (d !== want) begin
      n_err++; $display("FAIL mid_const got %h want %h", d, want);
    end
    if (d !== e.data) begin
      n_err++; $display("FAIL mid_data got %h want %h", d, e.data);
    end
    if (l !== e.last) begin
      n_err++; $display("FAIL mid_last got %b want %b", l, e.last);
    end
  endtask

  task automatic test_last();
    pix_t d;
    logic l;
    int n;
    exp_t e;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_pix = 0;
    for (int p = 0; p < 4; p++) begin
      set_rand(128, 256);
      push_expected();
      send_beats(CIN, 10);
      collect(d, l, n);
      e = sb.pop_front();
      n_vec += 2;
      if (l !== (p == 2)) begin
        n_err++; $display("FAIL last_flag%0d got %b want %b", p, l, (p == 2));
      end
      if (d !== e.data) begin
        n_err++; $display("FAIL last_data%0d got %h want %h", p, d, e.data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_half();
    test_saturate();
    test_relu();
    test_random_bubbles();
    test_backpressure();
    test_reset_midstream();
    test_last();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fire4_squeeze_conv.md
# fire4_squeeze_conv

1x1 convolution engine for the fire4 squeeze layer. It accepts one input activation per beat, one input channel per beat. For each beat it drives the channel index to the fire4 squeeze weight ROM and multiplies the activation by all NUM weights the ROM returns combinationally. It accumulates NUM signed partial sums, then emits one output pixel of NUM ReLU'd, saturated channels to the fire4 expand stage.

## Interface
- WIDTH, 16: activation/weight/output word width, signed two's complement
- ADDR, 10: ROM address width
- NUM, 32: output channels (parallel MACs)
- CIN, 128: input channels per pixel; must satisfy CIN <= 2**ADDR
- FRAC, 8: fractional bits of the fixed-point format (Q(WIDTH-FRAC).FRAC)
- PIXELS, 3025: pixels per frame (55x55)
- ACCW, 2*WIDTH+8: accumulator width
- clk  input  1  clock; all logic on the rising edge
- rst  input  1  reset, synchronous, active-high
- act_valid  input  1  act_data valid
- act_ready  output  1  engine accepts act_data this cycle
- act_data  input  WIDTH  activation for input channel = current ch count
- rom_address  output  ADDR  weight ROM address = current ch count
- rom_out  input  WIDTH x [0:NUM-1]  weights from the ROM, combinational on rom_address
- out_valid  output  1  out_data holds a complete pixel
- out_ready  input  1  downstream accepts out_data
- out_data  output  WIDTH x [0:NUM-1]  result channels, held until accepted
- out_last  output  1  qualifies out_data as the last pixel of the frame

## Operation
- States:
  - ACC: accepting activations.
  - FLUSH1, FLUSH2: pipeline drain.
  - OUT: holding the result.
- act_ready = (state==ACC) && !rst.
- rom_address = ch zero-extended to ADDR. ch is a 0..CIN-1 counter; it is 0 outside ACC.
- Beat = act_valid && act_ready. On a beat:
  - prod[k] <= act_data * rom_out[k], signed, 2*WIDTH bits; p_valid <= 1.
  - ch increments.
  - When ch==CIN-1: ch wraps to 0 and the state goes to FLUSH1.
- With no beat, p_valid <= 0.
- When p_valid is set, acc[k] <= acc[k] + sign_extend(prod[k]) to ACCW bits, no overflow check.
- FLUSH1 -> FLUSH2 unconditionally. FLUSH2 -> OUT unconditionally.
- In FLUSH2, each channel is computed and registered into out_data[k]:
  - r = acc[k] >>> FRAC, arithmetic shift.
  - If r < 0, result 0 (ReLU).
  - If r > 2^(WIDTH-1)-1, result 0x7FFF for WIDTH=16 (saturation).
  - Otherwise result r[WIDTH-1:0].
- In FLUSH2, out_last is registered as (pix==PIXELS-1).
- In OUT, out_valid=1.
- On out_valid && out_ready:
  - State -> ACC.
  - All acc cleared to 0.
  - pix increments; it wraps to 0 after PIXELS-1.
- out_data and out_last change only in FLUSH2. They are stable while out_valid=1 and out_ready=0.
- Gaps in act_valid are allowed anywhere inside a pixel. The accumulation result does not depend on bubble placement.
- rst clears, in the same edge, regardless of state:
  - state -> ACC; ch, pix = 0.
  - p_valid = 0; all acc = 0.
  - out_valid = 0, out_data = 0, out_last = 0.
- A partially accumulated pixel is discarded on rst. The next pixel starts fresh at channel 0, pixel 0.

## Timing
- Reset values: act_ready=0 while rst is high, then 1. rom_address=0, out_valid=0, out_data all 0, out_last=0.
- The ROM path is combinational: rom_out is sampled in the same cycle rom_address is driven.
- The product is registered at the beat edge; accumulation happens on the following edge.
- Last beat accepted at edge T: state is FLUSH1 in cycle T+1 and FLUSH2 in cycle T+2. The final acc is visible in T+2. out_valid=1 from cycle T+3.
- Latency is therefore 3 cycles from the last beat to out_valid.
- No beat is accepted from FLUSH1 until the cycle after the out handshake. Throughput is CIN+3 cycles per pixel when out_ready is held at 1.
- out_ready high in the first OUT cycle gives a one-cycle out_valid pulse; act_ready returns on the next cycle.

## Test plan
- All weights 0x0080 (0.5), act 0x0100 (1.0), 128 back-to-back beats:
  - Every out_data[k]=0x4000.
  - out_valid asserts exactly 3 cycles after the 128th beat.
- All weights 0x0100, act 0x0100, 128 beats:
  - Raw sum is 0x8000, so every channel saturates to 0x7FFF.
- Weights 0xFF00 (-1.0) on even k, 0x0100 on odd k, act 0x0100:
  - Even channels give 0 (ReLU); odd channels give 0x7FFF.
  - act 0x0001 instead gives odd channels 0x0080 (128 x 256 >>> 8).
- Random act_valid bubbles with random weights/activations: out_data matches the golden model bit-exactly, including the truncating arithmetic shift on negative sums.
- out_ready low for 10 cycles in OUT:
  - out_data stable, act_ready=0, rom_address=0.
  - The pixel after release is correct, i.e. acc was cleared.
- Stream 50 beats then pulse rst, then a full pixel with act 0x0100 and weights 0x0080: result 0x4000, no carry-over.
- PIXELS=3 override, 4 pixels: out_last=1 only on pixel 3; pixel 4 has out_last=0 (wrap).
